// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage valid/ready register pipeline with bubble collapsing.
// A stage is free to load when it is empty or when everything downstream of it moves.
module dff_pipe #(
    parameter int unsigned       WIDTH   = 8,
    parameter int unsigned       DEPTH   = 3,
    parameter logic [WIDTH-1:0]  RST_VAL = '0,
    parameter logic [WIDTH-1:0]  SET_VAL = '1,
    localparam int unsigned      CW      = $clog2(DEPTH + 1)
) (
    input  logic             CK,
    input  logic             RS,
    input  logic             ST,
    input  logic [WIDTH-1:0] D,
    input  logic             D_V,
    output logic             D_R,
    output logic [WIDTH-1:0] Q,
    output logic             Q_V,
    input  logic             Q_R,
    output logic [CW-1:0]    CNT
);

    logic [WIDTH-1:0] dat_q [DEPTH];
    logic [WIDTH-1:0] dat_d [DEPTH];
    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH-1:0] rdy;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             acc, xfer_out;

    // Ready ripples from the output end back toward the input.
    always_comb begin
        logic r;
        rdy = '0;
        r   = Q_R | ~v_q[DEPTH-1];
        rdy[DEPTH-1] = r;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            r      = r | ~v_q[i];
            rdy[i] = r;
        end
    end

    assign D_R      = rdy[0] & ~RS & ~ST;
    assign acc      = D_V & D_R;
    assign xfer_out = v_q[DEPTH-1] & Q_R;

    always_comb begin
        v_d   = v_q;
        dat_d = dat_q;
        cnt_d = cnt_q;
        if (ST) begin
            v_d   = '0;
            cnt_d = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                dat_d[i] = SET_VAL;
            end
        end else begin
            if (rdy[0]) begin
                v_d[0] = acc;
                // Data only moves with a valid beat, so an unaccepted X on D never lands.
                if (acc) begin
                    dat_d[0] = D;
                end
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (rdy[i]) begin
                    v_d[i] = v_q[i-1];
                    if (v_q[i-1]) begin
                        dat_d[i] = dat_q[i-1];
                    end
                end
            end
            cnt_d = cnt_q + CW'(acc) - CW'(xfer_out);
        end
    end

    always_ff @(posedge CK) begin
        if (RS) begin
            v_q   <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                dat_q[i] <= RST_VAL;
            end
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
            dat_q <= dat_d;
        end
    end

    assign Q   = dat_q[DEPTH-1];
    assign Q_V = v_q[DEPTH-1];
    assign CNT = cnt_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: a DEPTH=3 instance and a DEPTH=1 instance,
// each with a scoreboard queue fed on accept and drained on output transfer.
module tb_dff_pipe;

    logic       CK = 1'b0;
    logic       RS, ST;
    logic [7:0] D, D1;
    logic       D_V, D_V1, Q_R, Q_R1;
    logic       D_R, D_R1, Q_V, Q_V1;
    logic [7:0] Q, Q1;
    logic [1:0] CNT;
    logic [0:0] CNT1;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb0[$];
    logic [7:0] sb1[$];

    always #5 CK = ~CK;

    dff_pipe #(
        .WIDTH  (8),
        .DEPTH  (3),
        .RST_VAL(8'hA5),
        .SET_VAL(8'h3C)
    ) u_dut (
        .CK (CK),
        .RS (RS),
        .ST (ST),
        .D  (D),
        .D_V(D_V),
        .D_R(D_R),
        .Q  (Q),
        .Q_V(Q_V),
        .Q_R(Q_R),
        .CNT(CNT)
    );

    dff_pipe #(
        .WIDTH  (8),
        .DEPTH  (1),
        .RST_VAL(8'h00),
        .SET_VAL(8'hFF)
    ) u_dut1 (
        .CK (CK),
        .RS (RS),
        .ST (ST),
        .D  (D1),
        .D_V(D_V1),
        .D_R(D_R1),
        .Q  (Q1),
        .Q_V(Q_V1),
        .Q_R(Q_R1),
        .CNT(CNT1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input string tag, inout logic [7:0] sb[$], input logic [7:0] obs);
        logic [7:0] exp;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_underflow observed=%0h expected=none", tag, obs);
        end else begin
            exp = sb.pop_front();
            chk(tag, {24'h0, obs}, {24'h0, exp});
        end
    endtask

    // Record handshakes just before the edge, then advance one cycle.
    task automatic tick();
        logic flush;
        #1;
        flush = RS | ST;
        if (!flush) begin
            if (D_V && D_R)   sb0.push_back(D);
            if (Q_V && Q_R)   sb_pop("q_data", sb0, Q);
            if (D_V1 && D_R1) sb1.push_back(D1);
            if (Q_V1 && Q_R1) sb_pop("q1_data", sb1, Q1);
        end
        @(posedge CK);
        #1;
        if (flush) begin
            sb0.delete();
            sb1.delete();
        end
    endtask

    initial begin
        logic       m_v1;
        logic [2:0] qr_pat;
        RS = 1'b1; ST = 1'b0;
        D = '0; D_V = 1'b0; Q_R = 1'b0;
        D1 = '0; D_V1 = 1'b0; Q_R1 = 1'b0;
        @(negedge CK);

        // Reset
        chk("d_r_in_rs", D_R, 1'b0);
        tick();
        chk("rst_q", Q, 8'hA5);
        chk("rst_qv", Q_V, 1'b0);
        chk("rst_cnt", CNT, 2'd0);
        chk("rst_q1", Q1, 8'h00);
        RS = 1'b0;
        #1;
        chk("d_r_after_rs", D_R, 1'b1);

        // Streaming, no stall
        Q_R = 1'b1;
        D_V = 1'b1;
        for (int k = 0; k < 4; k++) begin
            D = 8'(k + 1);
            #1;
            chk("stream_dr", D_R, 1'b1);
            chk("stream_qv", Q_V, (k == 3) ? 1'b1 : 1'b0);
            tick();
        end
        D_V = 1'b0;
        repeat (3) tick();
        chk("stream_qv_end", Q_V, 1'b0);
        chk("stream_cnt_end", CNT, 2'd0);

        // Fill against a stalled output
        Q_R = 1'b0;
        D_V = 1'b1;
        for (int k = 0; k < 5; k++) begin
            D = 8'h21 + 8'(k);
            #1;
            chk("fill_dr", D_R, (k < 3) ? 1'b1 : 1'b0);
            tick();
        end
        chk("full_cnt", CNT, 2'd3);
        chk("full_q", Q, 8'h21);
        chk("full_qv", Q_V, 1'b1);
        Q_R = 1'b1;
        D = 8'h26;
        #1;
        chk("full_release_dr", D_R, 1'b1);
        tick();
        chk("full_inout_cnt", CNT, 2'd3);
        D_V = 1'b0;
        repeat (3) tick();
        chk("drain_cnt", CNT, 2'd0);

        // Bubble collapse
        Q_R = 1'b0;
        D_V = 1'b1; D = 8'h11;
        tick();
        D_V = 1'b0;
        tick();
        D_V = 1'b1; D = 8'h22;
        tick();
        D_V = 1'b0;
        repeat (2) tick();
        chk("bubble_cnt", CNT, 2'd2);
        chk("bubble_q", Q, 8'h11);
        chk("bubble_qv", Q_V, 1'b1);
        chk("bubble_full_dr", D_R, 1'b1);
        Q_R = 1'b1;
        repeat (2) tick();
        chk("bubble_drain_cnt", CNT, 2'd0);

        // Set/flush mid-stream, then RS+ST together
        Q_R = 1'b0;
        D_V = 1'b1; D = 8'h33;
        tick();
        D = 8'h44;
        tick();
        D_V = 1'b0;
        chk("pre_st_cnt", CNT, 2'd2);
        ST = 1'b1;
        D_V = 1'b1; D = 8'h55;
        #1;
        chk("st_dr", D_R, 1'b0);
        tick();
        ST = 1'b0;
        D_V = 1'b0;
        chk("st_q", Q, 8'h3C);
        chk("st_qv", Q_V, 1'b0);
        chk("st_cnt", CNT, 2'd0);
        chk("st_q1", Q1, 8'hFF);
        RS = 1'b1; ST = 1'b1;
        tick();
        RS = 1'b0; ST = 1'b0;
        chk("rs_st_q", Q, 8'hA5);
        chk("rs_st_cnt", CNT, 2'd0);
        chk("rs_st_q1", Q1, 8'h00);

        // DEPTH=1 with toggling downstream ready
        m_v1   = 1'b0;
        qr_pat = 3'b101;
        D_V1   = 1'b1;
        for (int k = 0; k < 12; k++) begin
            logic exp_dr;
            D1   = 8'h40 + 8'(k);
            Q_R1 = qr_pat[k % 3];
            #1;
            exp_dr = Q_R1 | ~m_v1;
            chk("d1_qv", Q_V1, m_v1);
            chk("d1_dr", D_R1, exp_dr);
            if (exp_dr) m_v1 = 1'b1;
            tick();
        end
        D_V1 = 1'b0;
        Q_R1 = 1'b1;
        tick();
        chk("d1_empty_qv", Q_V1, 1'b0);
        chk("d1_empty_cnt", CNT1, 1'b0);

        chk("sb0_left", sb0.size(), 0);
        chk("sb1_left", sb1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
